seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//  Time-multiplexed driver for the Basys3 4-digit seven-segment display; sits downstream of the letter decoder.
//  Takes four 8-bit segment patterns (active-low, bit7=dp) and scans them onto shared an/seg/dp pins.
//  Uses a refresh counter and a per-digit blanking gap to suppress ghosting.
//  A load strobe captures new patterns, which are applied only at a frame boundary (no tearing).
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  REFRESH_HZ    1000         per-digit slot rate; slot length DIV = CLK_HZ/REFRESH_HZ cycles
//  BLANK_CYCLES  64           cycles at start of each slot with all anodes off; requires DIV >= BLANK_CYCLES+2
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  pat0..pat3  in   8   segment patterns digit0 (rightmost)..digit3; active-low {dp,g..a}
//  load        in   1   1-cycle strobe: capture pat0..pat3 into pending register
//  digit_en    in   4   per-digit enable; 0 = digit stays dark during its slot
//  an          out  4   anode drive, active-low, one-hot-low or all 1
//  seg         out  7   cathodes a..g, active-low
//  dp          out  1   decimal point, active-low
//  frame_tick  out  1   1-cycle pulse at start of each frame (slot of digit0, cnt=0)
//  busy_pend   out  1   1 while a loaded pattern set awaits application
// BEHAVIOUR
//  Reset (async assert, sync-free deassert): an=4'hF, seg=7'h7F, dp=1, frame_tick=0, busy_pend=0.
//   Reset also clears cnt=0, idx=0; shadow and pending patterns = 8'hFF (blank).
//  Counters: cnt counts 0..DIV-1, wrapping to 0; on wrap idx increments mod 4 (3->0).
//  Phase FSM per slot: BLANK when cnt<BLANK_CYCLES, SHOW otherwise.
//   - BLANK: an=4'hF, seg=7'h7F, dp=1.
//   - SHOW:  an[idx]=0 (others 1) if digit_en[idx], else an=4'hF.
//     seg=shadow[idx][6:0] and dp=shadow[idx][7] when enabled; otherwise 7'h7F / 1.
//  an/seg/dp/frame_tick are registered and updated in the same cycle as cnt/idx.
//   Outputs reflect the cnt/idx values currently held (no extra lag).
//  load=1: pending<=pat0..3 and busy_pend<=1 on the next edge; a later load before application overwrites pending.
//  Application: on the edge where idx wraps 3->0 (cnt DIV-1 -> 0), if busy_pend then shadow<=pending, busy_pend<=0.
//   frame_tick=1 that same cycle.
//  Load coinciding with application: the old pending is applied; the new pats go to pending; busy_pend stays 1.
//  digit_en is sampled live each cycle (not shadowed); changing it mid-slot takes effect next cycle.
//  Reset mid-scan: immediate blank outputs, scan restarts at idx=0 BLANK.
//   Shadow returns to blank, so nothing is shown until the first load is applied at the following frame boundary.
//  Widths: cnt is $clog2(DIV) bits; no other arithmetic.
// TESTING (bench params CLK_HZ=1600, REFRESH_HZ=100 -> DIV=16, BLANK_CYCLES=4)
//  1. Reset held then released -> an=F, seg=7F, dp=1; first frame_tick 64 cycles after release; display stays blank.
//  2. load with pat0=8'hC0, pat1=8'hF9, digit_en=F -> busy_pend=1 until next wrap.
//     Then in slot0 SHOW (cnt 4..15): an=E, seg=40; in slot1: an=D, seg=79.
//  3. Blank gap check -> for every slot, cnt 0..3 gives an=F; exactly 12 SHOW cycles per slot; frame period 64 cycles.
//  4. digit_en=4'b1010 -> slots 0 and 2 show an=F for the whole slot; slots 1 and 3 drive an=D/7.
//  5. load A, then load B mid-frame -> only B is applied at the wrap; load on the wrap edge -> A applied, B pending, busy_pend=1.
//  6. rst_n low mid-SHOW of slot 2 -> an=F asynchronously; after release the scan restarts at idx=0 with a blank shadow.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit active-low seven-segment display.
// Patterns are double-buffered and swapped only at frame boundaries.
module seven_seg_scan #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] pat0,
   input  logic [7:0] pat1,
   input  logic [7:0] pat2,
   input  logic [7:0] pat3,
   input  logic       load,
   input  logic [3:0] digit_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick,
   output logic       busy_pend
);

   localparam int DIV   = CLK_HZ / REFRESH_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
   localparam phase_t PH_RESET = (BLANK_CYCLES == 0) ? PH_SHOW : PH_BLANK;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   phase_t           phase_q, phase_d;
   logic [3:0][7:0]  shadow_q, shadow_d;
   logic [3:0][7:0]  pending_q, pending_d;
   logic             busy_q, busy_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             frame_wrap;

   always_comb begin
      wrap       = (cnt_q == CNT_MAX);
      frame_wrap = wrap && (idx_q == 2'd3);
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      idx_d      = wrap ? idx_q + 2'd1 : idx_q;

      phase_d = phase_q;
      if (wrap) begin
         phase_d = PH_BLANK;
      end
      if (cnt_d == BLANK_END) begin
         phase_d = PH_SHOW;
      end

      // Old pending goes live at the frame edge even if a new load lands on it.
      shadow_d  = shadow_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      if (frame_wrap && busy_q) begin
         shadow_d = pending_q;
         busy_d   = 1'b0;
      end
      if (load) begin
         pending_d = {pat3, pat2, pat1, pat0};
         busy_d    = 1'b1;
      end

      // Outputs are computed from next-state values so they line up with cnt/idx.
      an_d   = 4'hF;
      seg_d  = 7'h7F;
      dp_d   = 1'b1;
      tick_d = frame_wrap;
      if (phase_d == PH_SHOW && digit_en[idx_d]) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = shadow_d[idx_d][6:0];
         dp_d  = shadow_d[idx_d][7];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         phase_q   <= PH_RESET;
         shadow_q  <= {4{8'hFF}};
         pending_q <= {4{8'hFF}};
         busy_q    <= 1'b0;
         an_q      <= 4'hF;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         phase_q   <= phase_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         tick_q    <= tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;
   assign busy_pend  = busy_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: frame-level reference model feeds a queue,
// a negedge monitor compares every cycle; directed phases cover the listed scenarios.
module tb_seven_seg_scan;

   localparam int DIV   = 16;
   localparam int BLANK = 4;
   localparam int FRAME = 4 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pat0 = 8'hFF, pat1 = 8'hFF, pat2 = 8'hFF, pat3 = 8'hFF;
   logic       load = 1'b0;
   logic [3:0] digit_en = 4'hF;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;
   logic       busy_pend;

   seven_seg_scan #(
      .CLK_HZ(1600),
      .REFRESH_HZ(100),
      .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pat0(pat0),
      .pat1(pat1),
      .pat2(pat2),
      .pat3(pat3),
      .load(load),
      .digit_en(digit_en),
      .an(an),
      .seg(seg),
      .dp(dp),
      .frame_tick(frame_tick),
      .busy_pend(busy_pend)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
      logic       bp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   // Reference model: time since reset release, frame-level double buffer.
   int         t;
   logic [7:0] sh[4];
   logic [7:0] pd[4];
   bit         busy;

   function automatic exp_t model_out();
      exp_t e;
      int pos, d;
      pos  = t % DIV;
      d    = (t / DIV) % 4;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      if (pos >= BLANK && digit_en[d]) begin
         e.an  = 4'hF & ~(4'b0001 << d);
         e.seg = sh[d][6:0];
         e.dp  = sh[d][7];
      end
      e.ft = (t > 0) && (t % FRAME == 0);
      e.bp = busy;
      return e;
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            t = 0;
            busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
               sh[i] = 8'hFF;
               pd[i] = 8'hFF;
            end
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, bp: 1'b0};
            exp_q.delete();
            exp_q.push_back(e);
         end else begin
            if (((t + 1) % FRAME == 0) && busy) begin
               for (int i = 0; i < 4; i++) sh[i] = pd[i];
               busy = 1'b0;
            end
            if (load) begin
               pd[0] = pat0; pd[1] = pat1; pd[2] = pat2; pd[3] = pat3;
               busy = 1'b1;
            end
            t++;
            exp_q.push_back(model_out());
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("outputs{an,seg,dp,ft,bp}", {18'd0, an, seg, dp, frame_tick, busy_pend}, {18'd0, e});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ft(output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!frame_tick && cyc < 200);
      if (!frame_tick) chk("frame_tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic load_pats(input logic [7:0] p0, p1, p2, p3);
      pat0 = p0; pat1 = p1; pat2 = p2; pat3 = p3;
      load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int show_cnt[4];
      int blank_bad, n_d, n_7, n_other;
      logic [7:0] a_p[4], b_p[4], c_p[4];

      // 1: reset, release, first frame tick
      step(3);
      chk("reset_an", an, 4'hF);
      chk("reset_seg", seg, 7'h7F);
      chk("reset_dp", dp, 1'b1);
      chk("reset_busy", busy_pend, 1'b0);
      rst_n = 1'b1;
      wait_ft(cyc);
      chk("first_tick_latency", cyc, 32'd64);

      // 2: load and display two digits
      load_pats(8'hC0, 8'hF9, 8'hFF, 8'hFF);
      chk("busy_after_load", busy_pend, 1'b1);
      wait_ft(cyc);
      chk("busy_after_apply", busy_pend, 1'b0);
      step(BLANK);
      chk("slot0_an", an, 4'hE);
      chk("slot0_seg", seg, 7'h40);
      step(DIV);
      chk("slot1_an", an, 4'hD);
      chk("slot1_seg", seg, 7'h79);

      // 3: blank gap and frame period
      wait_ft(cyc);
      blank_bad = 0;
      for (int i = 0; i < 4; i++) show_cnt[i] = 0;
      for (int k = 0; k < FRAME; k++) begin
         if ((k % DIV) < BLANK) begin
            if (an !== 4'hF) blank_bad++;
         end else if (an !== 4'hF) begin
            show_cnt[k / DIV]++;
         end
         step(1);
      end
      chk("frame_period", frame_tick, 1'b1);
      chk("blank_gap_an", blank_bad, 32'd0);
      for (int i = 0; i < 4; i++) chk("show_cycles_per_slot", show_cnt[i], 32'd12);

      // 4: digit_en mask
      digit_en = 4'b1010;
      n_d = 0; n_7 = 0; n_other = 0;
      for (int k = 0; k < FRAME; k++) begin
         if (an === 4'hD) n_d++;
         else if (an === 4'h7) n_7++;
         else if (an !== 4'hF) n_other++;
         step(1);
      end
      chk("en_mask_slot1", n_d, 32'd12);
      chk("en_mask_slot3", n_7, 32'd12);
      chk("en_mask_dark", n_other, 32'd0);
      digit_en = 4'hF;

      // 5: overwrite before apply, and load on the wrap edge
      for (int i = 0; i < 4; i++) begin
         a_p[i] = 8'($urandom);
         b_p[i] = 8'($urandom);
         c_p[i] = 8'($urandom);
      end
      step(5);
      load_pats(a_p[0], a_p[1], a_p[2], a_p[3]);
      step(10);
      load_pats(b_p[0], b_p[1], b_p[2], b_p[3]);
      wait_ft(cyc);
      step(BLANK);
      chk("overwrite_B_applied", seg, {25'd0, b_p[0][6:0]});
      wait_ft(cyc);
      step(2);
      load_pats(a_p[0], a_p[1], a_p[2], a_p[3]);
      step(FRAME - 4);
      load_pats(c_p[0], c_p[1], c_p[2], c_p[3]);
      chk("wrap_load_tick", frame_tick, 1'b1);
      chk("wrap_load_busy", busy_pend, 1'b1);
      step(BLANK);
      chk("wrap_load_A_shown", seg, {25'd0, a_p[0][6:0]});
      wait_ft(cyc);
      step(BLANK);
      chk("wrap_load_C_next", seg, {25'd0, c_p[0][6:0]});

      // random traffic checked by the scoreboard
      for (int k = 0; k < 20 * FRAME; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            load_pats(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         end else begin
            if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
            step(1);
         end
      end

      // 6: async reset mid-SHOW of slot 2
      digit_en = 4'hF;
      cyc = 0;
      while (an !== 4'hB && cyc < 200) begin
         step(1);
         cyc++;
      end
      chk("reach_slot2_show", an, 4'hB);
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_an", an, 4'hF);
      chk("async_reset_seg", seg, 7'h7F);
      chk("async_reset_busy", busy_pend, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(BLANK);
      chk("restart_slot0_an", an, 4'hE);
      chk("restart_blank_shadow", seg, 7'h7F);
      step(FRAME + 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
